// File: rtl/pw_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | pw_stream_pkg
// | Shared state encodings, channel codes and slot helper for the assembler.
// | Revision: 1.0
// +----------------------------------------------------------------------------
package pw_stream_pkg;

    localparam logic [1:0] ST_RST_WAIT = 2'd0;
    localparam logic [1:0] ST_COLLECT  = 2'd1;
    localparam logic [1:0] ST_EMIT     = 2'd2;

    localparam int CH_DATA = 0;
    localparam int CH_MGMT = 1;

    // Word 0 lands in the MSBs, so slot idx starts (NUM_WORDS-1-idx) words up.
    function automatic int slot_lsb(input int idx, input int num_words, input int data_w);
        return (num_words - 1 - idx) * data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pw_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | pw_word_packer
// | Password accumulator: slot registers, word index and overflow flag.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module pw_word_packer
    import pw_stream_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_WORDS = 3,
    parameter int IDX_W     = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        clr,
    output logic [NUM_WORDS*DATA_W-1:0] acc,
    output logic [IDX_W-1:0]            idx,
    output logic                        ovf
);

    localparam logic [IDX_W-1:0] c_num_words = IDX_W'(NUM_WORDS);
    localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);

    logic [IDX_W-1:0] r_idx;
    logic             r_ovf;

    genvar s;
    generate
        for (s = 0; s < NUM_WORDS; s++) begin : g_slot
            localparam int               c_lsb      = slot_lsb(s, NUM_WORDS, DATA_W);
            localparam logic [IDX_W-1:0] c_slot_idx = IDX_W'(s);

            logic [DATA_W-1:0] r_word;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_word <= '0;
                end else if (clr) begin
                    r_word <= '0;
                end else if (wr_en && (r_idx == c_slot_idx)) begin
                    r_word <= wr_data;
                end
            end

            assign acc[c_lsb +: DATA_W] = r_word;
        end
    endgenerate

    // Words past the last slot are discarded; only the sticky flag records them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_idx <= '0;
            r_ovf <= 1'b0;
        end else if (wr_en) begin
            if (r_idx < c_num_words) begin
                r_idx <= r_idx + c_idx_one;
            end else begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign idx = r_idx;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/pw_stream_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | pw_stream_assembler
// | Avalon-ST sink that packs data words into a password and emits on commit.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module pw_stream_assembler
    import pw_stream_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_WORDS = 3,
    parameter int CH_W      = 1,
    parameter int CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [CH_W-1:0]                  in_channel,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [NUM_WORDS*DATA_W-1:0]      out_data,
    output logic [$clog2(NUM_WORDS+1)-1:0]   out_count,
    output logic                             out_overflow,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CNT_W-1:0]                 drop_count,
    output logic [CNT_W-1:0]                 emit_count
);

    localparam int IDX_W = $clog2(NUM_WORDS + 1);
    localparam int ACC_W = NUM_WORDS * DATA_W;

    localparam logic [CH_W-1:0]  c_ch_data = CH_W'(CH_DATA);
    localparam logic [CH_W-1:0]  c_ch_mgmt = CH_W'(CH_MGMT);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_out_data;
    logic [IDX_W-1:0] r_out_count;
    logic             r_out_overflow;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_drop_count;
    logic [CNT_W-1:0] r_emit_count;

    logic [ACC_W-1:0] w_acc;
    logic [IDX_W-1:0] w_idx;
    logic             w_ovf;
    logic             w_accept;
    logic             w_is_data;
    logic             w_is_mgmt;
    logic             w_wr;
    logic             w_clr;
    logic             w_commit;
    logic             w_drop;

    assign in_ready  = (r_state == ST_COLLECT);
    assign w_accept  = in_valid && in_ready;
    assign w_is_data = (in_channel == c_ch_data);
    assign w_is_mgmt = (in_channel == c_ch_mgmt);
    assign w_wr      = w_accept && w_is_data;
    assign w_clr     = w_accept && w_is_mgmt;
    // A commit with nothing collected is only a sync marker.
    assign w_commit  = w_clr && (w_idx != '0);
    assign w_drop    = w_accept && !w_is_data && !w_is_mgmt;

    pw_word_packer #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_wr),
        .wr_data (in_data),
        .clr     (w_clr),
        .acc     (w_acc),
        .idx     (w_idx),
        .ovf     (w_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_RST_WAIT;
            r_out_data     <= '0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
            r_out_valid    <= 1'b0;
        end else begin
            case (r_state)
                ST_RST_WAIT: begin
                    r_state <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (w_commit) begin
                        r_out_data     <= w_acc;
                        r_out_count    <= w_idx;
                        r_out_overflow <= w_ovf;
                        r_out_valid    <= 1'b1;
                        r_state        <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_COLLECT;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_RST_WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
            r_emit_count <= '0;
        end else begin
            if (w_drop && (r_drop_count != c_cnt_max)) begin
                r_drop_count <= r_drop_count + c_cnt_one;
            end
            if (r_out_valid && out_ready && (r_emit_count != c_cnt_max)) begin
                r_emit_count <= r_emit_count + c_cnt_one;
            end
        end
    end

    assign out_data     = r_out_data;
    assign out_count    = r_out_count;
    assign out_overflow = r_out_overflow;
    assign out_valid    = r_out_valid;
    assign drop_count   = r_drop_count;
    assign emit_count   = r_emit_count;

endmodule
`default_nettype wire

// File: tb/tb_pw_stream_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_pw_stream_assembler
// | Directed scoreboard bench for the password stream assembler.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module tb_pw_stream_assembler;

    logic        clk;
    logic        reset_n;
    logic [15:0] in_data;
    logic [1:0]  in_channel;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] out_data;
    logic [1:0]  out_count;
    logic        out_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] drop_count;
    logic [15:0] emit_count;

    typedef struct {
        logic [47:0] d;
        logic [1:0]  c;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   n_vec;
    int   n_err;

    pw_stream_assembler #(
        .DATA_W    (16),
        .NUM_WORDS (3),
        .CH_W      (2),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .in_channel   (in_channel),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_overflow (out_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .drop_count   (drop_count),
        .emit_count   (emit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [47:0] d, input logic [1:0] c, input logic o);
        exp_t e;
        e.d = d;
        e.c = c;
        e.o = o;
        q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [1:0] ch, input logic [15:0] d);
        int n;
        in_valid   = 1'b1;
        in_channel = ch;
        in_data    = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Output monitor: a handshake at the next posedge is visible here.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 64'(out_data), 64'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.d));
                chk("out_count", 64'(out_count), 64'(e.c));
                chk("out_overflow", 64'(out_overflow), 64'(e.o));
            end
        end
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_channel = '0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_count", 64'(out_count), 64'(0));
        chk("rst_out_overflow", 64'(out_overflow), 64'(0));
        chk("rst_drop_count", 64'(drop_count), 64'(0));
        chk("rst_emit_count", 64'(emit_count), 64'(0));

        reset_n = 1'b1;
        @(negedge clk);

        // Sync marker then full password
        send(2'd1, 16'h0000);
        chk("empty_commit_no_valid", 64'(out_valid), 64'(0));
        send(2'd0, 16'h0004);
        send(2'd0, 16'ha53c);
        send(2'd0, 16'hf15b);
        push(48'h0004a53cf15b, 2'd3, 1'b0);
        send(2'd1, 16'h0000);
        chk("valid_after_commit", 64'(out_valid), 64'(1));
        repeat (2) @(negedge clk);
        chk("emit_count_1", 64'(emit_count), 64'(1));

        // Short password
        send(2'd0, 16'h55aa);
        send(2'd0, 16'h6633);
        push(48'h55aa66330000, 2'd2, 1'b0);
        send(2'd1, 16'h0000);

        // Overflow
        send(2'd0, 16'h0001);
        send(2'd0, 16'h0002);
        send(2'd0, 16'h0003);
        send(2'd0, 16'h0004);
        push(48'h000100020003, 2'd3, 1'b1);
        send(2'd1, 16'h0000);

        // Backpressure with a beat offered during EMIT
        send(2'd0, 16'habcd);
        send(2'd0, 16'h1234);
        out_ready = 1'b0;
        push(48'habcd12340000, 2'd2, 1'b0);
        send(2'd1, 16'h0000);
        in_valid   = 1'b1;
        in_channel = 2'd0;
        in_data    = 16'hdead;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_out_data", 64'(out_data), 64'(48'habcd12340000));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // Reserved channel in mid-password; also proves the EMIT beat was ignored
        send(2'd0, 16'h1111);
        send(2'd2, 16'h9999);
        chk("drop_count_1", 64'(drop_count), 64'(1));
        send(2'd0, 16'h2222);
        send(2'd0, 16'h3333);
        push(48'h111122223333, 2'd3, 1'b0);
        send(2'd1, 16'h0000);
        repeat (3) @(negedge clk);
        chk("emit_count_5", 64'(emit_count), 64'(5));
        chk("queue_drained_pre_reset", 64'(q.size()), 64'(0));

        // Reset in mid-password
        send(2'd0, 16'h7777);
        send(2'd0, 16'h8888);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_out_data", 64'(out_data), 64'(0));
        chk("mid_rst_out_count", 64'(out_count), 64'(0));
        chk("mid_rst_drop_count", 64'(drop_count), 64'(0));
        chk("mid_rst_emit_count", 64'(emit_count), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(2'd0, 16'h0a0b);
        send(2'd0, 16'h0c0d);
        send(2'd0, 16'h0e0f);
        push(48'h0a0b0c0d0e0f, 2'd3, 1'b0);
        send(2'd1, 16'h0000);
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'(0));
        chk("emit_count_after_rst", 64'(emit_count), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
